// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider with signed/unsigned modes, flush abort and sign fix-up.
// Latency: start edge is edge 0; o_done is high for the cycle after edge WIDTH; results registered.
// Backpressure: none; o_busy stalls the pipeline during RUN and DONE; i_start is ignored while running.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  // r_quo starts as the dividend magnitude and is shifted out MSB-first
  // while quotient bits are shifted in at the LSB end.
  logic [WIDTH-1:0] r_quo;
  // Settled remainder is always below the divisor, so WIDTH bits hold it;
  // the WIDTH+1-bit partial remainder exists only as the shifted trial value.
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dsr;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic             w_accept;
  logic             w_last;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_accept = (r_state != S_RUN) && i_start && !i_flush;
  assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));

  // Operand magnitudes; negating the most-negative value yields 2^(WIDTH-1) as unsigned, which is correct.
  assign w_a_neg  = i_signed & i_dividend[WIDTH-1];
  assign w_b_neg  = i_signed & i_divisor[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~i_dividend + 1'b1) : i_dividend;
  assign w_b_mag  = w_b_neg ? (~i_divisor + 1'b1) : i_divisor;

  // One restoring step: shift in the next dividend bit, subtract if it fits (no borrow).
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_dsr};
  assign w_ge      = ~w_diff[WIDTH];
  assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

  // Sign fix-up; divide-by-zero forces all-ones quotient, and the remainder
  // naturally comes back as the original dividend once its sign is restored.
  assign w_q_fix = r_dz ? {WIDTH{1'b1}} : (r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt);
  assign w_r_fix = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush overrides everything, including a start.
  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (i_start) w_state_nxt = S_RUN;
        S_RUN:   if (w_last)  w_state_nxt = S_DONE;
        S_DONE:  w_state_nxt = i_start ? S_RUN : S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_dsr       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dz        <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_quo   <= w_a_mag;
      r_rem   <= '0;
      r_dsr   <= w_b_mag;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_dz    <= (i_divisor == '0);
    end else if ((r_state == S_RUN) && !i_flush) begin
      r_cnt <= r_cnt + CW'(1);
      r_quo <= w_quo_nxt;
      r_rem <= w_rem_nxt;
      if (w_last) begin
        r_quotient  <= w_q_fix;
        r_remainder <= w_r_fix;
      end
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_quotient  = r_quotient;
  assign o_remainder = r_remainder;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit (WIDTH=32) against an arithmetic reference model.
// Drives and samples on the falling edge; directed corner cases plus random operands.
// Covers reset, latency, signed/zero/overflow cases, flush, start-in-run and back-to-back.
module tb_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         resetn;
  logic         i_start;
  logic         i_signed;
  logic [W-1:0] i_dividend;
  logic [W-1:0] i_divisor;
  logic         i_flush;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_quotient;
  logic [W-1:0] o_remainder;

  int errors = 0;
  int checks = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .i_start     (i_start),
    .i_signed    (i_signed),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .i_flush     (i_flush),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero,
  // and the 64-bit result of most-negative / -1 truncates back to most-negative.
  task automatic ref_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
  endtask

  // Present a start at the falling edge; returns at the falling edge after edge 0,
  // with operand inputs scrambled so the DUT must have latched them.
  task automatic start_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    i_start    = 1'b1;
    i_signed   = sgn;
    i_dividend = a;
    i_divisor  = b;
    @(negedge clk);
    i_start    = 1'b0;
    i_signed   = 1'($urandom);
    i_dividend = $urandom;
    i_divisor  = $urandom;
  endtask

  // Count falling edges until o_done is seen; 0 means the bound expired.
  task automatic wait_done(output int edges);
    edges = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (o_done) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; i_start = 1'b0; i_signed = 1'b0; i_flush = 1'b0;
    i_dividend = '0; i_divisor = '0;
    #12;
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++; $display("FAIL reset_flags busy=%b done=%b required 0 0", o_busy, o_done);
    end
    checks++;
    if (o_quotient !== '0 || o_remainder !== '0) begin
      errors++; $display("FAIL reset_results q=%h r=%h required 0 0", o_quotient, o_remainder);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency();
    int e;
    bit busy_ok;
    start_div(1'b0, 32'd100, 32'd7);
    checks++;
    if (o_busy !== 1'b1 || o_done !== 1'b0) begin
      errors++; $display("FAIL edge0_busy busy=%b done=%b required 1 0", o_busy, o_done);
    end
    busy_ok = 1'b1;
    e = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (o_busy !== 1'b1) busy_ok = 1'b0;
      if (o_done) begin e = k; break; end
    end
    checks++;
    if (e != 32) begin
      errors++; $display("FAIL latency done_after_edge=%0d required 32", e);
    end
    checks++;
    if (!busy_ok) begin
      errors++; $display("FAIL busy_during_run busy dropped required 1");
    end
    checks++;
    if (o_quotient !== 32'd14 || o_remainder !== 32'd2) begin
      errors++; $display("FAIL div_100_7 q=%0d r=%0d required 14 2", o_quotient, o_remainder);
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL done_single_cycle busy=%b done=%b required 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_corners();
    bit           sg [6];
    logic [W-1:0] a  [6];
    logic [W-1:0] b  [6];
    logic [W-1:0] eq, er;
    int e;
    sg[0] = 1; a[0] = 32'hFFFFFFF9; b[0] = 32'd2;
    sg[1] = 1; a[1] = 32'd7;        b[1] = 32'hFFFFFFFE;
    sg[2] = 0; a[2] = 32'h12345678; b[2] = 32'd0;
    sg[3] = 1; a[3] = 32'h80000000; b[3] = 32'hFFFFFFFF;
    sg[4] = 1; a[4] = 32'hFFFFFF00; b[4] = 32'd0;
    sg[5] = 0; a[5] = 32'hFFFFFFFF; b[5] = 32'hFFFFFFFF;
    for (int i = 0; i < 6; i++) begin
      ref_div(sg[i], a[i], b[i], eq, er);
      start_div(sg[i], a[i], b[i]);
      wait_done(e);
      checks++;
      if (e != 32 || o_quotient !== eq || o_remainder !== er) begin
        errors++;
        $display("FAIL corner%0d edges=%0d q=%h r=%h required edges=32 q=%h r=%h",
                 i, e, o_quotient, o_remainder, eq, er);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    bit sgn;
    logic [W-1:0] a, b, eq, er;
    int e;
    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom);
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = ~W'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      ref_div(sgn, a, b, eq, er);
      start_div(sgn, a, b);
      wait_done(e);
      checks++;
      if (e != 32 || o_quotient !== eq || o_remainder !== er) begin
        errors++;
        $display("FAIL random%0d s=%0d a=%h b=%h edges=%0d q=%h r=%h required q=%h r=%h",
                 i, sgn, a, b, e, o_quotient, o_remainder, eq, er);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] pq, pr, eq, er;
    int e;
    bit no_done;
    pq = o_quotient;
    pr = o_remainder;
    start_div(1'b0, 32'd5000, 32'd3);
    no_done = 1'b1;
    repeat (9) begin
      @(negedge clk);
      if (o_done) no_done = 1'b0;
    end
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || !no_done) begin
      errors++; $display("FAIL flush_state busy=%b done=%b required 0 0", o_busy, o_done);
    end
    checks++;
    if (o_quotient !== pq || o_remainder !== pr) begin
      errors++; $display("FAIL flush_hold q=%h r=%h required %h %h", o_quotient, o_remainder, pq, pr);
    end
    @(negedge clk);
    ref_div(1'b1, 32'hFFFFF000, 32'd9, eq, er);
    start_div(1'b1, 32'hFFFFF000, 32'd9);
    wait_done(e);
    checks++;
    if (e != 32 || o_quotient !== eq || o_remainder !== er) begin
      errors++; $display("FAIL restart_after_flush edges=%0d q=%h r=%h required 32 %h %h",
                         e, o_quotient, o_remainder, eq, er);
    end
    // Flush while DONE: return to idle, results hold.
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_quotient !== eq || o_remainder !== er) begin
      errors++; $display("FAIL flush_in_done busy=%b done=%b q=%h r=%h required 0 0 %h %h",
                         o_busy, o_done, o_quotient, o_remainder, eq, er);
    end
    // Start and flush together: flush wins.
    i_start = 1'b1; i_flush = 1'b1; i_dividend = 32'd9; i_divisor = 32'd2;
    @(negedge clk);
    i_start = 1'b0; i_flush = 1'b0;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++; $display("FAIL start_with_flush busy=%b required 0", o_busy);
    end
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++; $display("FAIL start_with_flush_idle busy=%b done=%b required 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_start_in_run();
    logic [W-1:0] eq, er;
    int e;
    ref_div(1'b0, 32'd1000, 32'd33, eq, er);
    start_div(1'b0, 32'd1000, 32'd33);
    repeat (5) @(negedge clk);
    i_start = 1'b1; i_signed = 1'b1; i_dividend = 32'hFFFFFFF0; i_divisor = 32'd3;
    @(negedge clk);
    i_start = 1'b0;
    wait_done(e);
    checks++;
    if (e != 26 || o_quotient !== eq || o_remainder !== er) begin
      errors++; $display("FAIL start_in_run edges=%0d q=%h r=%h required 26 %h %h",
                         e, o_quotient, o_remainder, eq, er);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] eq1, er1, eq2, er2;
    int e;
    ref_div(1'b1, 32'hFFFF8000, 32'd123, eq1, er1);
    ref_div(1'b0, 32'hDEADBEEF, 32'd77, eq2, er2);
    start_div(1'b1, 32'hFFFF8000, 32'd123);
    wait_done(e);
    checks++;
    if (e != 32 || o_quotient !== eq1 || o_remainder !== er1) begin
      errors++; $display("FAIL b2b_first edges=%0d q=%h r=%h required 32 %h %h",
                         e, o_quotient, o_remainder, eq1, er1);
    end
    start_div(1'b0, 32'hDEADBEEF, 32'd77);
    checks++;
    if (o_busy !== 1'b1 || o_done !== 1'b0) begin
      errors++; $display("FAIL b2b_restart busy=%b done=%b required 1 0", o_busy, o_done);
    end
    wait_done(e);
    checks++;
    if (e != 32 || o_quotient !== eq2 || o_remainder !== er2) begin
      errors++; $display("FAIL b2b_second edges=%0d q=%h r=%h required 32 %h %h",
                         e, o_quotient, o_remainder, eq2, er2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] eq, er;
    int e;
    start_div(1'b0, 32'd77777, 32'd10);
    repeat (10) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_quotient !== '0 || o_remainder !== '0) begin
      errors++; $display("FAIL reset_mid busy=%b done=%b q=%h r=%h required 0 0 0 0",
                         o_busy, o_done, o_quotient, o_remainder);
    end
    @(negedge clk);
    resetn = 1'b1;
    ref_div(1'b1, 32'd12345, 32'hFFFFFFF9, eq, er);
    start_div(1'b1, 32'd12345, 32'hFFFFFFF9);
    wait_done(e);
    checks++;
    if (e != 32 || o_quotient !== eq || o_remainder !== er) begin
      errors++; $display("FAIL after_reset edges=%0d q=%h r=%h required 32 %h %h",
                         e, o_quotient, o_remainder, eq, er);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_corners();
    test_random();
    test_flush();
    test_start_in_run();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
